// File: rtl/snoop_bus_ctrl_pkg.sv
// snoop_bus_ctrl_pkg: bus request, snoop response and fill codes shared by the coherence bus
package snoop_bus_ctrl_pkg;
  typedef enum logic [1:0] {BUS_NONE, BUS_RD, BUS_RDX, BUS_UPGR} bus_req_e;
  typedef enum logic [1:0] {RSP_NONE, RSP_MISS, RSP_SHARED, RSP_FLUSH} snoop_rsp_e;
  typedef enum logic [1:0] {FILL_NONE, FILL_E, FILL_S, GRANT_M} fill_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/snoop_bus_ctrl_if.sv
// snoop_bus_ctrl_if: flattened per-cache bus plus main memory port of the coherence controller
interface snoop_bus_ctrl_if #(
  parameter int NUM_CACHE  = 4,
  parameter int LINE_WIDTH = 512,
  parameter int LA         = 58
);
  logic [2*NUM_CACHE-1:0]          cac2bus_bus_req;
  logic [NUM_CACHE-1:0]            cac2bus_write_back;
  logic [LA*NUM_CACHE-1:0]         cac2bus_addr;
  logic [LINE_WIDTH*NUM_CACHE-1:0] cac2bus_data;
  logic [2*NUM_CACHE-1:0]          cac2bus_bus_rsp;
  logic [2*NUM_CACHE-1:0]          bus2cac_bus_req;
  logic [LA-1:0]                   bus2cac_addr;
  logic [LINE_WIDTH-1:0]           bus2cac_data;
  logic [2*NUM_CACHE-1:0]          bus2cac_bus_rsp;
  logic                            mem_req;
  logic                            mem_we;
  logic [LA-1:0]                   mem_addr;
  logic [LINE_WIDTH-1:0]           mem_wdata;
  logic [LINE_WIDTH-1:0]           mem_rdata;
  logic                            mem_ack;
  modport slave (
    input  cac2bus_bus_req, cac2bus_write_back, cac2bus_addr, cac2bus_data, cac2bus_bus_rsp, mem_rdata, mem_ack,
    output bus2cac_bus_req, bus2cac_addr, bus2cac_data, bus2cac_bus_rsp, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cac2bus_bus_req, cac2bus_write_back, cac2bus_addr, cac2bus_data, cac2bus_bus_rsp, mem_rdata, mem_ack,
    input  bus2cac_bus_req, bus2cac_addr, bus2cac_data, bus2cac_bus_rsp, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first unmasked pending cache at or after ptr_i
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [N-1:0] eff;
  assign eff = req_i & ~mask_i;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++)
      if (!any_o && eff[(int'(ptr_i) + k) % N]) begin
        any_o = 1'b1;
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
      end
  end
endmodule

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: MESI bus controller arbitrating cache requests, snooping peers and sourcing fills
module snoop_bus_ctrl
  import snoop_bus_ctrl_pkg::*;
#(
  parameter int NUM_CACHE  = 4,
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  snoop_bus_ctrl_if.slave   bus,
  output logic              proto_err
);
  localparam int LA = ADDR_WIDTH - $clog2(LINE_WIDTH / 8);
  localparam int IW = idx_w(NUM_CACHE);
  localparam logic [2:0] IDLE = 3'd0, SNOOP = 3'd1, MEM_RD = 3'd2, MEM_WR = 3'd3, RESP = 3'd4;
  logic [2:0]              state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d, idx_q, idx_d, gnt_idx;
  logic [NUM_CACHE-1:0]    mask_q, mask_d, oh_q, oh_d, done_q, done_d, pend, gnt;
  logic [1:0]              type_q, type_d, fill;
  logic                    wb_q, wb_d, shared_q, shared_d, flush_q, flush_d, err_q, err_d, gnt_any;
  logic                    mreq_q, mreq_d, mwe_q, mwe_d;
  logic [LINE_WIDTH-1:0]   data_q, data_d, bdata_q, bdata_d, mwdata_q, mwdata_d;
  logic [LA-1:0]           addr_q, addr_d, maddr_q, maddr_d;
  logic [2*NUM_CACHE-1:0]  breq_q, breq_d, brsp_q, brsp_d;
  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_CACHE; i++)
      pend[i] = bus.cac2bus_write_back[i] | (bus.cac2bus_bus_req[2*i +: 2] != BUS_NONE);
  end
  rr_arbiter #(.N(NUM_CACHE), .IW(IW)) u_arb (
    .req_i(pend), .mask_i(mask_q), .ptr_i(ptr_q), .gnt_o(gnt), .idx_o(gnt_idx), .any_o(gnt_any)
  );
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    oh_d     = oh_q;
    type_d   = type_q;
    wb_d     = wb_q;
    done_d   = done_q;
    shared_d = shared_q;
    flush_d  = flush_q;
    data_d   = data_q;
    addr_d   = addr_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (gnt_any) begin
        idx_d    = gnt_idx;
        oh_d     = gnt;
        wb_d     = bus.cac2bus_write_back[gnt_idx];
        type_d   = bus.cac2bus_bus_req[2*int'(gnt_idx) +: 2];
        addr_d   = bus.cac2bus_addr[LA*int'(gnt_idx) +: LA];
        data_d   = wb_d ? bus.cac2bus_data[LINE_WIDTH*int'(gnt_idx) +: LINE_WIDTH] : data_q;
        done_d   = '0;
        shared_d = 1'b0;
        flush_d  = 1'b0;
        state_d  = wb_d ? MEM_WR : SNOOP;
      end
      SNOOP: begin
        // ascending scan keeps the lowest-index flusher; any later flush is a protocol error
        for (int j = 0; j < NUM_CACHE; j++)
          if (!oh_q[j] && !done_q[j] && bus.cac2bus_bus_rsp[2*j +: 2] != RSP_NONE) begin
            done_d[j] = 1'b1;
            if (bus.cac2bus_bus_rsp[2*j +: 2] inside {RSP_SHARED, RSP_FLUSH}) shared_d = 1'b1;
            if (bus.cac2bus_bus_rsp[2*j +: 2] == RSP_FLUSH) begin
              if (flush_d) err_d = 1'b1;
              else data_d = bus.cac2bus_data[LINE_WIDTH*j +: LINE_WIDTH];
              flush_d = 1'b1;
            end
          end
        if ((done_d | oh_q) == '1)
          state_d = type_q == BUS_UPGR ? RESP : flush_d ? MEM_WR : MEM_RD;
      end
      MEM_RD: if (bus.mem_ack) begin
        data_d  = bus.mem_rdata;
        state_d = RESP;
      end
      MEM_WR:  state_d = bus.mem_ack ? RESP : MEM_WR;
      default: state_d = IDLE;
    endcase
    fill     = wb_d ? FILL_E : type_d == BUS_RD ? (shared_d ? FILL_S : FILL_E) : GRANT_M;
    breq_d   = '0;
    brsp_d   = '0;
    for (int j = 0; j < NUM_CACHE; j++) begin
      breq_d[2*j +: 2] = (state_d == SNOOP && !oh_d[j]) ? type_d : BUS_NONE;
      brsp_d[2*j +: 2] = (state_d == RESP && oh_d[j]) ? fill : FILL_NONE;
    end
    bdata_d  = state_d == RESP ? data_d : bdata_q;
    mreq_d   = state_d == MEM_RD || state_d == MEM_WR;
    mwe_d    = state_d == MEM_WR;
    maddr_d  = mreq_d ? addr_d : maddr_q;
    mwdata_d = mwe_d ? data_d : mwdata_q;
    ptr_d    = state_q == RESP ? (idx_q == IW'(NUM_CACHE - 1) ? '0 : idx_q + 1'b1) : ptr_q;
    mask_d   = state_q == RESP ? oh_q : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
      oh_q     <= '0;
      type_q   <= '0;
      wb_q     <= 1'b0;
      done_q   <= '0;
      shared_q <= 1'b0;
      flush_q  <= 1'b0;
      data_q   <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      breq_q   <= '0;
      brsp_q   <= '0;
      bdata_q  <= '0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      oh_q     <= oh_d;
      type_q   <= type_d;
      wb_q     <= wb_d;
      done_q   <= done_d;
      shared_q <= shared_d;
      flush_q  <= flush_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      breq_q   <= breq_d;
      brsp_q   <= brsp_d;
      bdata_q  <= bdata_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  assign bus.bus2cac_bus_req = breq_q;
  assign bus.bus2cac_bus_rsp = brsp_q;
  assign bus.bus2cac_addr    = addr_q;
  assign bus.bus2cac_data    = bdata_q;
  assign bus.mem_req         = mreq_q;
  assign bus.mem_we          = mwe_q;
  assign bus.mem_addr        = maddr_q;
  assign bus.mem_wdata       = mwdata_q;
  assign proto_err           = err_q;
endmodule
